// File: rtl/stage_ctrl.sv
// stage_ctrl: game-flow sequencer owning the display state code.
// Moves TITLE -> STAGE1..3 -> SUCCESS/FAIL screens from button pulses, gameplay events
// and the frame tick. It also tracks hearts, collected keys, stage-clear flags and the
// dark-stage flag.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   frame_tick      - one pulse per video frame
//   btn_start/back  - debounced button pulses
//   hit, key_pick, goal - gameplay event pulses
//   state           - screen code (0 TITLE .. 8 FAIL)
//   heart, key_find - remaining hearts, sticky collected keys
//   play_valid      - bit0 gameplay active, bits 3:1 stage cleared
//   isDark          - high while in STAGE3
module stage_ctrl #(
  parameter int unsigned SUCCESS_FRAMES = 120,
  parameter int unsigned FAIL_FRAMES    = 180,
  parameter int unsigned INVULN_FRAMES  = 60,
  parameter int unsigned MAX_HEARTS     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_start,
  input  logic       btn_back,
  input  logic       hit,
  input  logic [1:0] key_pick,
  input  logic       goal,
  output logic [3:0] state,
  output logic [1:0] heart,
  output logic [1:0] key_find,
  output logic [3:0] play_valid,
  output logic       isDark
);

  typedef enum logic [3:0] {
    StTitle    = 4'd0,
    StStaff    = 4'd1,
    StStage1   = 4'd2,
    StSuccess1 = 4'd3,
    StStage2   = 4'd4,
    StSuccess2 = 4'd5,
    StStage3   = 4'd6,
    StSuccess3 = 4'd7,
    StFail     = 4'd8
  } st_e;

  localparam logic [7:0] SuccLast   = 8'(SUCCESS_FRAMES - 1);
  localparam logic [7:0] FailLast   = 8'(FAIL_FRAMES - 1);
  localparam logic [7:0] InvulnLoad = 8'(INVULN_FRAMES);
  localparam logic [1:0] HeartLoad  = 2'(MAX_HEARTS);

  st_e        state_q, state_d;
  logic [1:0] heart_q, heart_d;
  logic [1:0] key_q, key_d;
  logic [2:0] clear_q, clear_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] inv_q, inv_d;
  logic       active_q, dark_q;

  logic [1:0] key_now;
  logic       fatal;
  logic       screen_done;
  logic       is_stage_d;

  always_comb begin
    state_d     = state_q;
    heart_d     = heart_q;
    key_d       = key_q;
    clear_d     = clear_q;
    timer_d     = timer_q;
    inv_d       = inv_q;
    key_now     = key_q | key_pick;
    fatal       = 1'b0;
    screen_done = 1'b0;

    unique case (state_q)
      StTitle: begin
        if (btn_start) begin
          state_d = StStage1;
        end else if (btn_back) begin
          state_d = StStaff;
        end
      end
      StStaff: begin
        if (btn_start || btn_back) begin
          state_d = StTitle;
        end
      end
      StStage1, StStage2, StStage3: begin
        key_d = key_now;
        if (frame_tick && (inv_q != 8'd0)) begin
          inv_d = inv_q - 8'd1;
        end
        if (hit && (inv_q == 8'd0)) begin
          if (heart_q == 2'd1) begin
            fatal   = 1'b1;
            heart_d = 2'd0;
            state_d = StFail;
          end else begin
            heart_d = heart_q - 2'd1;
            inv_d   = InvulnLoad;
          end
        end
        if (!fatal) begin
          if (btn_back) begin
            state_d = StTitle;
          end else if (goal && (key_now == 2'b11)) begin
            unique case (state_q)
              StStage1: begin
                state_d    = StSuccess1;
                clear_d[0] = 1'b1;
              end
              StStage2: begin
                state_d    = StSuccess2;
                clear_d[1] = 1'b1;
              end
              default: begin
                state_d    = StSuccess3;
                clear_d[2] = 1'b1;
              end
            endcase
          end
        end
      end
      StSuccess1, StSuccess2, StSuccess3: begin
        // Timer saturates at the last frame; the exit fires on that same edge.
        if (frame_tick && (timer_q < SuccLast)) begin
          timer_d = timer_q + 8'd1;
        end
        screen_done = btn_start || (frame_tick && (timer_q == SuccLast));
        if (screen_done) begin
          unique case (state_q)
            StSuccess1: state_d = StStage2;
            StSuccess2: state_d = StStage3;
            default:    state_d = StTitle;
          endcase
        end
      end
      StFail: begin
        if (frame_tick && (timer_q < FailLast)) begin
          timer_d = timer_q + 8'd1;
        end
        if (btn_start || (frame_tick && (timer_q == FailLast))) begin
          state_d = StTitle;
        end
      end
      default: begin
        state_d = StTitle;
      end
    endcase

    is_stage_d = (state_d == StStage1) || (state_d == StStage2) || (state_d == StStage3);

    // Entry actions, applied on top of whatever the current state decided.
    if (state_d != state_q) begin
      timer_d = 8'd0;
      if (is_stage_d) begin
        heart_d = HeartLoad;
        key_d   = 2'b00;
        inv_d   = 8'd0;
      end else if (state_d == StTitle) begin
        heart_d = 2'd0;
        key_d   = 2'b00;
        inv_d   = 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StTitle;
      heart_q  <= 2'd0;
      key_q    <= 2'b00;
      clear_q  <= 3'b000;
      timer_q  <= 8'd0;
      inv_q    <= 8'd0;
      active_q <= 1'b0;
      dark_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      heart_q  <= heart_d;
      key_q    <= key_d;
      clear_q  <= clear_d;
      timer_q  <= timer_d;
      inv_q    <= inv_d;
      active_q <= is_stage_d;
      dark_q   <= (state_d == StStage3);
    end
  end

  assign state      = state_q;
  assign heart      = heart_q;
  assign key_find   = key_q;
  assign play_valid = {clear_q, active_q};
  assign isDark     = dark_q;

endmodule

// File: tb/tb_stage_ctrl.sv
module tb_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       btn_start;
  logic       btn_back;
  logic       hit;
  logic [1:0] key_pick;
  logic       goal;
  logic [3:0] state;
  logic [1:0] heart;
  logic [1:0] key_find;
  logic [3:0] play_valid;
  logic       isDark;

  int checks = 0;
  int errors = 0;

  stage_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_start  (btn_start),
    .btn_back   (btn_back),
    .hit        (hit),
    .key_pick   (key_pick),
    .goal       (goal),
    .state      (state),
    .heart      (heart),
    .key_find   (key_find),
    .play_valid (play_valid),
    .isDark     (isDark)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic p_start();
    btn_start = 1'b1; tick(); btn_start = 1'b0;
  endtask

  task automatic p_back();
    btn_back = 1'b1; tick(); btn_back = 1'b0;
  endtask

  task automatic p_hit();
    hit = 1'b1; tick(); hit = 1'b0;
  endtask

  task automatic p_goal();
    goal = 1'b1; tick(); goal = 1'b0;
  endtask

  task automatic p_key(input logic [1:0] k);
    key_pick = k; tick(); key_pick = 2'b00;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; tick();
      frame_tick = 1'b0; tick();
    end
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; btn_start = 1'b0; btn_back = 1'b0;
    hit = 1'b0; key_pick = 2'b00; goal = 1'b0;
    #2;
    tick(); tick();
    rst = 1'b0;
    check("rst_state", state, 0);
    check("rst_heart", heart, 0);
    check("rst_key", key_find, 0);
    check("rst_pv", play_valid, 0);
    check("rst_dark", isDark, 0);

    // Menu
    p_back();  check("staff", state, 1);
    p_back();  check("staff_back", state, 0);
    p_start();
    check("stage1", state, 2);
    check("stage1_heart", heart, 3);
    check("stage1_pv", play_valid, 4'b0001);

    // Keys and goal
    p_goal();       check("goal_nokey", state, 2);
    p_key(2'b01);   check("key_a", key_find, 2'b01);
    p_key(2'b10);   check("key_ab", key_find, 2'b11);
    p_goal();
    check("success1", state, 3);
    check("success1_pv", play_valid, 4'b0010);
    frames(119);    check("success1_hold", state, 3);
    frames(1);
    check("stage2_auto", state, 4);
    check("stage2_key", key_find, 0);
    check("stage2_heart", heart, 3);
    check("stage2_pv", play_valid, 4'b0011);

    // Hits and invulnerability
    p_hit();     check("hit1", heart, 2);
    frames(10);
    p_hit();     check("hit_invuln", heart, 2);
    frames(50);
    p_hit();     check("hit2", heart, 1);
    frames(60);
    p_hit();
    check("fatal_state", state, 8);
    check("fatal_heart", heart, 0);
    frames(179); check("fail_hold", state, 8);
    frames(1);
    check("fail_exit", state, 0);
    check("fail_exit_pv", play_valid, 4'b0010);

    // Fatal hit beats goal
    p_start();
    p_key(2'b11);
    p_hit(); frames(60);
    p_hit(); frames(60);
    check("sim_heart1", heart, 1);
    hit = 1'b1; goal = 1'b1; tick(); hit = 1'b0; goal = 1'b0;
    check("sim_fatal", state, 8);
    check("sim_fatal_heart", heart, 0);
    check("sim_fatal_key", key_find, 2'b11);
    p_start();   check("fail_skip", state, 0);

    // Non-fatal hit then goal
    p_start();
    p_key(2'b11);
    p_hit(); frames(60);
    hit = 1'b1; goal = 1'b1; tick(); hit = 1'b0; goal = 1'b0;
    check("sim_goal", state, 3);
    check("sim_goal_heart", heart, 1);

    // Dark stage and skip
    p_start();
    check("skip_stage2", state, 4);
    check("stage2_dark", isDark, 0);
    p_key(2'b11); p_goal();
    check("success2", state, 5);
    check("success2_pv", play_valid, 4'b0110);
    p_start();
    check("stage3", state, 6);
    check("stage3_dark", isDark, 1);
    check("stage3_pv", play_valid, 4'b0111);
    p_key(2'b11); p_goal();
    check("success3", state, 7);
    check("success3_pv", play_valid, 4'b1110);
    check("success3_dark", isDark, 0);
    p_start();
    check("title_end", state, 0);
    check("title_end_pv", play_valid, 4'b1110);
    check("title_end_heart", heart, 0);

    // Abandon a stage
    p_start();
    p_key(2'b01);
    p_back();
    check("abandon", state, 0);
    check("abandon_key", key_find, 0);
    check("abandon_heart", heart, 0);

    // Reset mid-play
    p_start();
    p_key(2'b11); p_goal(); p_start();
    check("pre_rst_state", state, 4);
    check("pre_rst_pv", play_valid, 4'b1111);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_state", state, 0);
    check("mid_rst_heart", heart, 0);
    check("mid_rst_key", key_find, 0);
    check("mid_rst_pv", play_valid, 0);
    check("mid_rst_dark", isDark, 0);

    // Reach STAGE2 with exactly stages 1 cleared, then reset
    p_start();
    p_key(2'b11); p_goal(); p_start();
    check("pre_rst2_pv", play_valid, 4'b0011);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_state", state, 0);
    check("rst2_pv", play_valid, 0);

    // Held start enters STAGE1 once and is then ignored
    btn_start = 1'b1;
    tick();      check("held_start", state, 2);
    tick(); tick();
    check("held_start_stay", state, 2);
    check("held_start_heart", heart, 3);
    btn_start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_ctrl.md
# stage_ctrl

Game-flow sequencer that owns the 4-bit `state` code consumed by the display compositor and the per-object draw blocks. It advances TITLE → STAGE1..3 → SUCCESS/FAIL screens from debounced button pulses, gameplay events and a frame tick. It also maintains hearts, collected keys, stage-clear flags and the dark-stage flag. All outputs are registered and feed `game_display` and the gameplay logic directly.

## Interface

Parameters:
- `SUCCESS_FRAMES`, default 120: frames a SUCCESSn screen is held before auto-advance (1..255).
- `FAIL_FRAMES`, default 180: frames the FAIL screen is held before returning to TITLE (1..255).
- `INVULN_FRAMES`, default 60: frames hits are ignored after a non-fatal hit (1..255).
- `MAX_HEARTS`, default 3: hearts loaded on stage entry (1..3).

Ports:
- `clk`, input, 1: system clock; the only clock.
- `rst`, input, 1: synchronous, active-high reset.
- `frame_tick`, input, 1: one-cycle pulse per video frame.
- `btn_start`, input, 1: one-cycle debounced pulse.
- `btn_back`, input, 1: one-cycle debounced pulse.
- `hit`, input, 1: one-cycle pulse when the player is damaged.
- `key_pick`, input, 2: one-cycle pulse per key (bit0 = key A, bit1 = key B).
- `goal`, input, 1: one-cycle pulse when the player touches the exit door.
- `state`, output, 4: 0 TITLE, 1 STAFF, 2 STAGE1, 3 SUCCESS1, 4 STAGE2, 5 SUCCESS2, 6 STAGE3, 7 SUCCESS3, 8 FAIL.
- `heart`, output, 2: remaining hearts.
- `key_find`, output, 2: sticky collected-key flags for the current stage.
- `play_valid`, output, 4: bit0 = gameplay active (state is STAGEn); bits 3:1 = stage 1..3 cleared (sticky).
- `isDark`, output, 1: high while state is STAGE3.

## Operation

- **Reset values** (applied when `rst` is high at a clock edge, overriding all other inputs):
  - `state` = 0, `heart` = 0, `key_find` = 0, `play_valid` = 0, `isDark` = 0.
  - Frame timer = 0, invulnerability counter = 0.
- **TITLE**:
  - `btn_start` → STAGE1.
  - else `btn_back` → STAFF.
- **STAFF**: `btn_start` or `btn_back` → TITLE.
- **Stage entry** (any transition into STAGEn): load `heart` = MAX_HEARTS; clear `key_find`, the invulnerability counter and the frame timer.
- **STAGEn**:
  - `key_pick[i]` sets `key_find[i]`.
  - A `hit` while the invulnerability counter is 0:
    - if `heart` = 1 → FAIL with `heart` = 0;
    - otherwise `heart` decrements and the counter loads INVULN_FRAMES.
  - The counter decrements on `frame_tick` while nonzero.
  - `goal` with `key_find` = 2'b11 (including keys set in the same cycle) → SUCCESSn, and sets `play_valid[n]`.
  - `goal` with an incomplete key set is ignored.
  - `btn_back` → TITLE (abandon).
- **Priority within a STAGE cycle**: fatal hit > `btn_back` > goal. A non-fatal hit and a qualifying goal in the same cycle: hit is applied, then the goal is taken (→ SUCCESSn with decremented `heart`).
- **SUCCESSn**:
  - The frame timer increments on `frame_tick`.
  - At `timer == SUCCESS_FRAMES - 1` with `frame_tick`, or on `btn_start`: SUCCESS1 → STAGE2, SUCCESS2 → STAGE3, SUCCESS3 → TITLE.
  - The timer clears on every state change.
- **FAIL**: the timer counts as in SUCCESSn up to FAIL_FRAMES. Exit to TITLE on expiry or `btn_start`. `key_find` and `heart` hold their values.
- **Entering TITLE** from STAGE/FAIL/SUCCESS3 clears `key_find` and `heart`. `play_valid[3:1]` clears only on `rst`.
- **Unused encodings 9..15**: next state is TITLE.
- **Derived outputs**: `play_valid[0]` and `isDark` are registered functions of the next state, so they change in the same edge as `state`.

## Timing

- Single clock domain. All inputs are sampled at the rising edge of `clk`, and every output changes only at that edge.
- **Latency**: one cycle from an input pulse to the new `state`/`heart`/`key_find`.
- **Timer**: 8-bit, no wrap. It saturates at its limit, and the transition fires on that edge.
- Pulses held longer than one cycle are treated as repeated events. In TITLE, a held `btn_start` enters STAGE1 once; later cycles in STAGE1 ignore `btn_start`.
- `rst` mid-stage returns everything to reset values on the next edge, including the clear flags.

## Test plan

- **Reset/menu**: `rst` 2 cycles, then `btn_back` → `state` = 1. Then `btn_back` → 0. Then `btn_start` → `state` = 2, `heart` = 3, `play_valid` = 4'b0001.
- **Keys/goal**: in STAGE1, `goal` alone → still 2. Then `key_pick` = 01, then 10 → `key_find` = 11. Then `goal` → `state` = 3, `play_valid` = 4'b0010. After 120 `frame_tick` → `state` = 4, `key_find` = 0.
- **Hits**: in STAGE2, `hit` → `heart` = 2. Second `hit` 10 frames later → ignored. `hit` after 60 frames → `heart` = 1. Next unprotected `hit` → `state` = 8, `heart` = 0. After 180 frames → `state` = 0.
- **Simultaneous events**: `heart` = 1, keys complete, `hit` and `goal` in the same cycle → `state` = 8. Repeat with `heart` = 2 → `state` = SUCCESSn, `heart` = 1.
- **Dark/skip**: reach STAGE3 → `isDark` = 1 on the same edge as `state` = 6. Clear it, then `btn_start` in SUCCESS3 → `state` = 0, `play_valid` = 4'b1110, `isDark` = 0.
- **Reset mid-play**: `rst` during STAGE2 with `play_valid` = 4'b0011 → all outputs 0 on the next edge.
